// File: rtl/uart_cmd_ctrl_if.sv
// Handshake bundle between uart_cmd_ctrl and its UART receiver, UART transmitter
// and arithmetic core. slave = the controller, master = the surrounding blocks.
interface uart_cmd_ctrl_if #(
  parameter int OP_BYTES  = 4,
  parameter int RES_BYTES = 8
);
  logic [7:0]             iRxByte;
  logic                   iRxDone;
  logic [7:0]             oOpcode;
  logic [OP_BYTES*8-1:0]  oOperandA;
  logic [OP_BYTES*8-1:0]  oOperandB;
  logic                   oStart;
  logic                   iDone;
  logic [RES_BYTES*8-1:0] iResult;
  logic [7:0]             oTxByte;
  logic                   oTxStart;
  logic                   iTxDone;
  logic                   oBusy;
  logic                   oErr;

  modport slave (
    input  iRxByte, iRxDone, iDone, iResult, iTxDone,
    output oOpcode, oOperandA, oOperandB, oStart, oTxByte, oTxStart, oBusy, oErr
  );

  modport master (
    output iRxByte, iRxDone, iDone, iResult, iTxDone,
    input  oOpcode, oOperandA, oOperandB, oStart, oTxByte, oTxStart, oBusy, oErr
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: collects opcode + two operands, launches the core, streams
// the result back byte-by-byte. Optional trailing XOR checksum byte: UART_CMD_CHECKSUM_EN.
module uart_cmd_ctrl #(
  parameter int OP_BYTES     = 4,
  parameter int RES_BYTES    = 8,
  parameter int TIMEOUT_CLKS = 1_250_000
) (
  input  logic           iClk,
  input  logic           iRstN,
  uart_cmd_ctrl_if.slave bus
);
  localparam int OPW  = OP_BYTES * 8;
  localparam int RESW = RES_BYTES * 8;
  localparam int MAXB = (OP_BYTES > RES_BYTES) ? OP_BYTES : RES_BYTES;
  localparam int CW   = $clog2(MAXB + 1);
  localparam int TW   = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] OP_LAST  = CW'(OP_BYTES - 1);
  localparam logic [CW-1:0] RES_LAST = CW'(RES_BYTES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    sIDLE, sRX_A, sRX_B,
`ifdef UART_CMD_CHECKSUM_EN
    sRX_CHK,
`endif
    sSTART, sWAIT, sTX_SEND, sTX_WAIT
  } state_t;

  state_t          r_state;
  logic [7:0]      r_opcode;
  logic [OPW-1:0]  r_opa;
  logic [OPW-1:0]  r_opb;
  logic            r_start;
  logic [7:0]      r_txbyte;
  logic            r_txstart;
  logic            r_err;
  logic [CW-1:0]   r_cnt;
  logic [TW-1:0]   r_to;
  logic [RESW-1:0] r_sh;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]      r_chk;
`endif

  logic            w_rx_state;
  logic            w_to_exp;
  logic [OPW-1:0]  w_opa_shift;
  logic [OPW-1:0]  w_opb_shift;
  logic [RESW-1:0] w_sh_next;

  assign w_rx_state = (r_state == sRX_A) || (r_state == sRX_B)
`ifdef UART_CMD_CHECKSUM_EN
                      || (r_state == sRX_CHK)
`endif
                      ;
  assign w_to_exp    = (r_to == TO_LAST);
  assign w_opa_shift = OPW'({r_opa, bus.iRxByte});
  assign w_opb_shift = OPW'({r_opb, bus.iRxByte});
  assign w_sh_next   = r_sh << 8;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state   <= sIDLE;
      r_opcode  <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_start   <= 1'b0;
      r_txbyte  <= '0;
      r_txstart <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_to      <= '0;
      r_sh      <= '0;
`ifdef UART_CMD_CHECKSUM_EN
      r_chk     <= '0;
`endif
    end else begin
      r_start   <= 1'b0;
      r_txstart <= 1'b0;
      r_err     <= 1'b0;
      // Inter-byte timer only ticks while a frame is being received
      if (w_rx_state) r_to <= bus.iRxDone ? '0 : r_to + TW'(1);
      else            r_to <= '0;

      case (r_state)
        sIDLE: if (bus.iRxDone) begin
          r_opcode <= bus.iRxByte;
          r_cnt    <= '0;
          r_state  <= sRX_A;
`ifdef UART_CMD_CHECKSUM_EN
          r_chk    <= bus.iRxByte;
`endif
        end
        sRX_A: if (bus.iRxDone) begin
          r_opa <= w_opa_shift;
`ifdef UART_CMD_CHECKSUM_EN
          r_chk <= r_chk ^ bus.iRxByte;
`endif
          if (r_cnt == OP_LAST) begin
            r_cnt   <= '0;
            r_state <= sRX_B;
          end else r_cnt <= r_cnt + CW'(1);
        end
        sRX_B: if (bus.iRxDone) begin
          r_opb <= w_opb_shift;
`ifdef UART_CMD_CHECKSUM_EN
          r_chk <= r_chk ^ bus.iRxByte;
`endif
          if (r_cnt == OP_LAST) begin
            r_cnt   <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            r_state <= sRX_CHK;
`else
            r_state <= sSTART;
            r_start <= 1'b1;
`endif
          end else r_cnt <= r_cnt + CW'(1);
        end
`ifdef UART_CMD_CHECKSUM_EN
        sRX_CHK: if (bus.iRxDone) begin
          if (bus.iRxByte == r_chk) begin
            r_state <= sSTART;
            r_start <= 1'b1;
          end else begin
            // Bad frame: skip the core and answer with a single 0xEE byte
            r_err     <= 1'b1;
            r_txbyte  <= 8'hEE;
            r_txstart <= 1'b1;
            r_cnt     <= RES_LAST;
            r_state   <= sTX_SEND;
          end
        end
`endif
        sSTART: r_state <= sWAIT;
        sWAIT: if (bus.iDone) begin
          r_sh      <= bus.iResult;
          r_txbyte  <= bus.iResult[RESW-1 -: 8];
          r_txstart <= 1'b1;
          r_cnt     <= '0;
          r_state   <= sTX_SEND;
        end
        sTX_SEND: r_state <= sTX_WAIT;
        sTX_WAIT: if (bus.iTxDone) begin
          if (r_cnt == RES_LAST) begin
            r_cnt   <= '0;
            r_state <= sIDLE;
          end else begin
            r_cnt     <= r_cnt + CW'(1);
            r_sh      <= w_sh_next;
            r_txbyte  <= w_sh_next[RESW-1 -: 8];
            r_txstart <= 1'b1;
            r_state   <= sTX_SEND;
          end
        end
        default: r_state <= sIDLE;
      endcase

      // Expiry loses to a coincident byte; otherwise abandon the frame
      if (w_rx_state && !bus.iRxDone && w_to_exp) begin
        r_state <= sIDLE;
        r_err   <= 1'b1;
        r_opa   <= '0;
        r_opb   <= '0;
        r_cnt   <= '0;
        r_to    <= '0;
      end
    end
  end

  assign bus.oOpcode   = r_opcode;
  assign bus.oOperandA = r_opa;
  assign bus.oOperandB = r_opb;
  assign bus.oStart    = r_start;
  assign bus.oTxByte   = r_txbyte;
  assign bus.oTxStart  = r_txstart;
  assign bus.oBusy     = (r_state != sIDLE);
  assign bus.oErr      = r_err;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: stimulus pushes expected oErr/oStart/oTxStart
// events (with their cycle stamps); a negedge monitor pops and compares them.
module tb_uart_cmd_ctrl;
  localparam int K_ERR = 0, K_START = 1, K_TX = 2;
  localparam int EV_NONE = 0, EV_START = 1, EV_CHKBAD = 2;

  typedef struct {
    int          kind;
    logic [63:0] d;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
  } exp_t;

  logic iClk;
  logic iRstN;
  int   cyc;
  int   last_acc;
  int   n_cmp;
  int   n_bad;
  exp_t exp_q[$];
  logic [7:0]  e_op;
  logic [31:0] e_a;
  logic [31:0] e_b;

  uart_cmd_ctrl_if #(.OP_BYTES(4), .RES_BYTES(8)) bus ();

  uart_cmd_ctrl #(.OP_BYTES(4), .RES_BYTES(8), .TIMEOUT_CLKS(100)) dut (
    .iClk (iClk),
    .iRstN(iRstN),
    .bus  (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [63:0] d, input logic [31:0] a,
                      input logic [31:0] b, input int cy);
    exp_t e;
    e.kind = kind; e.d = d; e.a = a; e.b = b; e.cyc = cy;
    exp_q.push_back(e);
  endtask

  task automatic mon_event(input int kind, input logic [63:0] d, input logic [31:0] a,
                           input logic [31:0] b);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: kind %0d data %0h at cycle %0d, expected no event", kind, d, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 64'(kind), 64'(e.kind));
      chk("event_cycle", 64'(cyc), 64'(e.cyc));
      chk("event_data", d, e.d);
      if (e.kind == K_START) begin
        chk("start_opA", {32'h0, a}, {32'h0, e.a});
        chk("start_opB", {32'h0, b}, {32'h0, e.b});
      end
    end
  endtask

  always @(negedge iClk) begin
    if (iRstN) begin
      if (bus.oErr)     mon_event(K_ERR, 64'h0, 32'h0, 32'h0);
      if (bus.oStart)   mon_event(K_START, {56'h0, bus.oOpcode}, bus.oOperandA, bus.oOperandB);
      if (bus.oTxStart) mon_event(K_TX, {56'h0, bus.oTxByte}, 32'h0, 32'h0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge iClk);
  endtask

  // Byte is accepted at the posedge after the driving negedge; responses land at cyc+1
  task automatic send_byte(input logic [7:0] b, input int ev);
    @(negedge iClk);
    bus.iRxByte = b;
    bus.iRxDone = 1'b1;
    if (ev == EV_START) push(K_START, {56'h0, e_op}, e_a, e_b, cyc + 1);
    else if (ev == EV_CHKBAD) begin
      push(K_ERR, 64'h0, 32'h0, 32'h0, cyc + 1);
      push(K_TX, 64'hEE, 32'h0, 32'h0, cyc + 1);
    end
    @(negedge iClk);
    bus.iRxDone = 1'b0;
    last_acc = cyc;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                            input bit good, input int gap);
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0] x;
    x = op ^ a[31:24] ^ a[23:16] ^ a[15:8] ^ a[7:0] ^ b[31:24] ^ b[23:16] ^ b[15:8] ^ b[7:0];
`endif
    e_op = op; e_a = a; e_b = b;
    send_byte(op, EV_NONE);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) idle(gap);
      send_byte(a[31-8*i -: 8], EV_NONE);
    end
`ifdef UART_CMD_CHECKSUM_EN
    for (int i = 0; i < 4; i++) send_byte(b[31-8*i -: 8], EV_NONE);
    send_byte(good ? x : (x ^ 8'h01), good ? EV_START : EV_CHKBAD);
`else
    for (int i = 0; i < 4; i++) send_byte(b[31-8*i -: 8], (i == 3 && good) ? EV_START : EV_NONE);
`endif
  endtask

  task automatic serve_tx(input logic [63:0] res, input int n, input bit use_done);
    int t;
    logic [7:0] bt;
    if (use_done) begin
      @(negedge iClk);
      bus.iDone   = 1'b1;
      bus.iResult = res;
      push(K_TX, {56'h0, res[63:56]}, 32'h0, 32'h0, cyc + 1);
      @(negedge iClk);
      bus.iDone   = 1'b0;
      bus.iResult = 64'h0;
    end
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!bus.oTxStart && t < 50) begin
        @(negedge iClk);
        t++;
      end
      chk("tx_start_seen", {63'h0, bus.oTxStart}, 64'h1);
      bt = res[63-8*i -: 8];
      idle(3);
      if (i == 2) send_byte(8'h5A, EV_NONE);
      chk("txbyte_hold", {56'h0, bus.oTxByte}, {56'h0, bt});
      chk("busy_in_tx", {63'h0, bus.oBusy}, 64'h1);
      @(negedge iClk);
      bus.iTxDone = 1'b1;
      if (i < n - 1) push(K_TX, {56'h0, res[55-8*i -: 8]}, 32'h0, 32'h0, cyc + 1);
      @(negedge iClk);
      bus.iTxDone = 1'b0;
    end
    chk("busy_after_tx", {63'h0, bus.oBusy}, 64'h0);
  endtask

  task automatic wait_empty(input int limit, input string nm);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < limit) begin
      @(negedge iClk);
      t++;
    end
    chk(nm, 64'(exp_q.size()), 64'h0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_opcode"}, {56'h0, bus.oOpcode}, 64'h0);
    chk({nm, "_opA"}, {32'h0, bus.oOperandA}, 64'h0);
    chk({nm, "_opB"}, {32'h0, bus.oOperandB}, 64'h0);
    chk({nm, "_txbyte"}, {56'h0, bus.oTxByte}, 64'h0);
    chk({nm, "_flags"}, {60'h0, bus.oStart, bus.oTxStart, bus.oBusy, bus.oErr}, 64'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    last_acc = 0;
    iRstN = 1'b0;
    bus.iRxByte = 8'h0;
    bus.iRxDone = 1'b0;
    bus.iDone   = 1'b0;
    bus.iResult = 64'h0;
    bus.iTxDone = 1'b0;
    idle(3);
    chk_all_zero("reset");
    iRstN = 1'b1;

    // Main frame; last A byte lands exactly on the timeout boundary and must win
    send_frame(8'h01, 32'h12345678, 32'h9ABCDEF0, 1'b1, 98);
    chk("frame1_opcode", {56'h0, bus.oOpcode}, 64'h01);
    chk("frame1_opA", {32'h0, bus.oOperandA}, 64'h12345678);
    chk("frame1_opB", {32'h0, bus.oOperandB}, 64'h9ABCDEF0);
    // Core busy ~50 cycles with a stray byte that must be dropped
    idle(20);
    send_byte(8'h55, EV_NONE);
    idle(28);
    chk("wait_opA_stable", {32'h0, bus.oOperandA}, 64'h12345678);
    chk("wait_opB_stable", {32'h0, bus.oOperandB}, 64'h9ABCDEF0);
    chk("wait_busy", {63'h0, bus.oBusy}, 64'h1);
    serve_tx(64'h0011223344556677, 8, 1'b1);
    wait_empty(10, "frame1_drained");

    // Truncated frame: opcode + 2 bytes, then silence
    send_byte(8'h07, EV_NONE);
    send_byte(8'hAA, EV_NONE);
    send_byte(8'hBB, EV_NONE);
    chk("partial_opA", {32'h0, bus.oOperandA}, 64'h5678AABB);
    push(K_ERR, 64'h0, 32'h0, 32'h0, last_acc + 100);
    wait_empty(150, "timeout_err_seen");
    idle(1);
    chk("timeout_idle", {63'h0, bus.oBusy}, 64'h0);
    chk("timeout_opA_clr", {32'h0, bus.oOperandA}, 64'h0);
    chk("timeout_opB_clr", {32'h0, bus.oOperandB}, 64'h0);
    send_frame(8'h02, 32'hCAFEF00D, 32'h01020304, 1'b1, 0);
    serve_tx(64'h8877665544332211, 8, 1'b1);
    wait_empty(10, "frame2_drained");

    // Reset after the 5th byte of a frame
    send_byte(8'h03, EV_NONE);
    send_byte(8'h11, EV_NONE);
    send_byte(8'h22, EV_NONE);
    send_byte(8'h33, EV_NONE);
    send_byte(8'h44, EV_NONE);
    chk("pre_reset_opA", {32'h0, bus.oOperandA}, 64'h11223344);
    iRstN = 1'b0;
    #1;
    chk_all_zero("midframe_reset");
    @(negedge iClk);
    iRstN = 1'b1;
    send_frame(8'h04, 32'hA5A55A5A, 32'h0F0FF0F0, 1'b1, 0);
    chk("post_reset_opA", {32'h0, bus.oOperandA}, 64'hA5A55A5A);
    chk("post_reset_opB", {32'h0, bus.oOperandB}, 64'h0F0FF0F0);
    serve_tx(64'hFEDCBA9876543210, 8, 1'b1);
    wait_empty(10, "frame3_drained");

`ifdef UART_CMD_CHECKSUM_EN
    // Operand bytes XOR to 0, so the correct checksum is the opcode 0x10
    send_frame(8'h10, 32'h12345678, 32'h9ABCDEF0, 1'b0, 0);
    serve_tx(64'hEE00000000000000, 1, 1'b0);
    wait_empty(10, "chkbad_drained");
    send_frame(8'h10, 32'h12345678, 32'h9ABCDEF0, 1'b1, 0);
    serve_tx(64'h0102030405060708, 8, 1'b1);
    wait_empty(10, "chkgood_drained");
`endif

    idle(5);
    wait_empty(1, "scoreboard_empty");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
